instr_fetch_unit: RTL and testbench



---
 rtl/instr_fetch_unit_if.sv | 25 ++
 rtl/instr_fetch_unit.sv | 146 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus.
// The fetch unit is the master, instruction memory the slave.
`timescale 1ns/1ps
interface instr_fetch_unit_if #(
   parameter int PC_WIDTH = 7
);
   logic                IMEM_REQ;
   logic [PC_WIDTH-1:0] IMEM_ADDR;
   logic                IMEM_ACK;
   logic [10:0]         IMEM_DATA;

   modport master (
      output IMEM_REQ,
      output IMEM_ADDR,
      input  IMEM_ACK,
      input  IMEM_DATA
   );

   modport slave (
      input  IMEM_REQ,
      input  IMEM_ADDR,
      output IMEM_ACK,
      output IMEM_DATA
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns PC and IR, fetches over a req/ack bus,
// and stalls the phase generator while a fetch is outstanding.
`timescale 1ns/1ps
module instr_fetch_unit #(
   parameter int          PC_WIDTH = 7,
   parameter int unsigned RESET_PC = 0,
   parameter int          TIMEOUT  = 15
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                IR_EN,
   input  logic                PC_EN,
   input  logic                PC_LOAD,
   instr_fetch_unit_if.master  imem,
   output logic [3:0]          OPCODE,
   output logic [6:0]          ADDR,
   output logic [PC_WIDTH-1:0] PC,
   output logic                STALL,
   output logic                FETCH_ERR
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam logic [7:0]          CNT_LAST = 8'(TIMEOUT - 1);
   localparam logic [PC_WIDTH-1:0] PC_RST   = PC_WIDTH'(RESET_PC);
   localparam logic [10:0]         IR_ABORT = 11'h780;

   state_t              state;
   state_t              state_d;
   logic                ir_en_q;
   logic                pc_en_q;
   logic                ir_rise;
   logic                pc_rise;
   logic [10:0]         ir;
   logic [10:0]         ir_d;
   logic                ir_ld;
   logic [7:0]          cnt;
   logic [7:0]          cnt_d;
   logic                err;
   logic                err_set;
   logic                addr_ld;
   logic                req;
   logic                stall;
   logic [PC_WIDTH-1:0] pc;
   logic [PC_WIDTH-1:0] addr_q;

   assign ir_rise = IR_EN & ~ir_en_q;
   assign pc_rise = PC_EN & ~pc_en_q;

   // FSM state register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   // Next state, stall and IR-load decisions for the fetch handshake.
   always_comb begin
      state_d = state;
      req     = 1'b0;
      stall   = 1'b0;
      ir_ld   = 1'b0;
      ir_d    = imem.IMEM_DATA;
      err_set = 1'b0;
      addr_ld = 1'b0;
      cnt_d   = cnt;
      unique case (state)
         IDLE: begin
            if (ir_rise) begin
               addr_ld = 1'b1;
               cnt_d   = '0;
               stall   = 1'b1;
               state_d = REQ;
            end
         end
         REQ: begin
            req = 1'b1;
            if (imem.IMEM_ACK) begin
               ir_ld   = 1'b1;
               state_d = HOLD;
            end else if (cnt == CNT_LAST) begin
               ir_ld   = 1'b1;
               ir_d    = IR_ABORT;
               err_set = 1'b1;
               state_d = HOLD;
            end else begin
               cnt_d = cnt + 8'd1;
               stall = 1'b1;
            end
         end
         HOLD: begin
            if (!IR_EN) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // PC, IR, fetch address, wait counter, error flag and edge detectors.
   always_ff @(posedge CLK) begin
      if (RST) begin
         pc      <= PC_RST;
         ir      <= '0;
         addr_q  <= PC_RST;
         cnt     <= '0;
         err     <= 1'b0;
         ir_en_q <= 1'b0;
         pc_en_q <= 1'b0;
      end else begin
         ir_en_q <= IR_EN;
         pc_en_q <= PC_EN;
         cnt     <= cnt_d;
         if (ir_ld) begin
            ir <= ir_d;
         end
         if (addr_ld) begin
            addr_q <= pc;
         end
         if (err_set) begin
            err <= 1'b1;
         end
         if (pc_rise) begin
            pc <= PC_LOAD ? PC_WIDTH'(ir[6:0])
                          : pc + PC_WIDTH'(1);
         end
      end
   end

   assign imem.IMEM_REQ  = req;
   assign imem.IMEM_ADDR = addr_q;
   assign OPCODE         = ir[10:7];
   assign ADDR           = ir[6:0];
   assign PC             = pc;
   assign STALL          = stall;
   assign FETCH_ERR      = err;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a per-cycle vector table
// followed by hand-written multi-cycle fetch, PC and reset sequences.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

   logic       clk;
   logic       rst;
   logic       ir_en;
   logic       pc_en;
   logic       pc_load;
   logic [3:0] opcode;
   logic [6:0] addr;
   logic [6:0] pc;
   logic       stall;
   logic       fetch_err;

   int n_chk  = 0;
   int n_fail = 0;

   instr_fetch_unit_if #(.PC_WIDTH(7)) bus ();

   instr_fetch_unit #(
      .PC_WIDTH(7),
      .RESET_PC(0),
      .TIMEOUT (15)
   ) dut (
      .CLK      (clk),
      .RST      (rst),
      .IR_EN    (ir_en),
      .PC_EN    (pc_en),
      .PC_LOAD  (pc_load),
      .imem     (bus),
      .OPCODE   (opcode),
      .ADDR     (addr),
      .PC       (pc),
      .STALL    (stall),
      .FETCH_ERR(fetch_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        ir_en;
      logic        pc_en;
      logic        pc_load;
      logic        ack;
      logic [10:0] data;
      logic        req;
      logic        stall;
      logic [6:0]  iaddr;
      logic [6:0]  pc;
      logic [3:0]  op;
      logic [6:0]  ad;
      logic        err;
   } vec_t;

   vec_t tv[7];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Hold IR_EN high and serve the request; ack_at is the REQ cycle
   // that gets ACK (0 = never). Returns REQ/STALL cycle counts.
   task automatic run_fetch(input int ack_at, input logic [10:0] data,
                            output int req_n, output int stall_n,
                            output logic [6:0] fa);
      bit started;
      bit done;
      started = 0;
      done    = 0;
      req_n   = 0;
      stall_n = 0;
      fa      = '0;
      for (int c = 0; c < 40; c++) begin
         step();
         ir_en         = 1'b1;
         bus.IMEM_DATA = data;
         bus.IMEM_ACK  = bus.IMEM_REQ && (req_n + 1 == ack_at);
         #1;
         if (started && !bus.IMEM_REQ) begin
            bus.IMEM_ACK = 1'b0;
            done = 1;
            break;
         end
         if (bus.IMEM_REQ) begin
            if (!started) fa = bus.IMEM_ADDR;
            started = 1;
            req_n++;
         end
         if (stall) stall_n++;
      end
      bus.IMEM_ACK = 1'b0;
      chk("fetch_completes", 32'(done), 32'd1);
   endtask

   task automatic to_idle();
      step();
      ir_en = 1'b0;
      step();
   endtask

   task automatic pc_pulse(input logic ld, input logic [6:0] exp,
                           input string nm);
      step();
      pc_en   = 1'b1;
      pc_load = ld;
      step();
      pc_en   = 1'b0;
      pc_load = 1'b0;
      #1;
      chk(nm, 32'(pc), 32'(exp));
   endtask

   int         rq;
   int         st;
   logic [6:0] fa;

   initial begin
      tv[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 11'h000,
                1'b0, 1'b0, 7'd0, 7'd0, 4'd0, 7'd0, 1'b0};
      tv[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 11'h000,
                1'b0, 1'b1, 7'd0, 7'd0, 4'd0, 7'd0, 1'b0};
      tv[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 11'h0C5,
                1'b1, 1'b0, 7'd0, 7'd0, 4'd0, 7'd0, 1'b0};
      tv[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 11'h000,
                1'b0, 1'b0, 7'd0, 7'd0, 4'd1, 7'd69, 1'b0};
      tv[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 11'h000,
                1'b0, 1'b0, 7'd0, 7'd0, 4'd1, 7'd69, 1'b0};
      tv[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 11'h000,
                1'b0, 1'b0, 7'd0, 7'd0, 4'd1, 7'd69, 1'b0};
      tv[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 11'h000,
                1'b0, 1'b0, 7'd0, 7'd1, 4'd1, 7'd69, 1'b0};

      rst           = 1'b1;
      ir_en         = 1'b0;
      pc_en         = 1'b0;
      pc_load       = 1'b0;
      bus.IMEM_ACK  = 1'b0;
      bus.IMEM_DATA = '0;
      step();
      step();
      rst = 1'b0;

      // Reset state, single-cycle-ACK fetch, one PC increment.
      for (int i = 0; i < 7; i++) begin
         step();
         ir_en         = tv[i].ir_en;
         pc_en         = tv[i].pc_en;
         pc_load       = tv[i].pc_load;
         bus.IMEM_ACK  = tv[i].ack;
         bus.IMEM_DATA = tv[i].data;
         #1;
         chk($sformatf("v%0d_req", i), 32'(bus.IMEM_REQ), 32'(tv[i].req));
         chk($sformatf("v%0d_stall", i), 32'(stall), 32'(tv[i].stall));
         chk($sformatf("v%0d_iaddr", i), 32'(bus.IMEM_ADDR),
             32'(tv[i].iaddr));
         chk($sformatf("v%0d_pc", i), 32'(pc), 32'(tv[i].pc));
         chk($sformatf("v%0d_op", i), 32'(opcode), 32'(tv[i].op));
         chk($sformatf("v%0d_addr", i), 32'(addr), 32'(tv[i].ad));
         chk($sformatf("v%0d_err", i), 32'(fetch_err), 32'(tv[i].err));
      end
      bus.IMEM_ACK = 1'b0;

      // ACK on the 5th REQ cycle: 1 IDLE + 4 waiting cycles stalled.
      run_fetch(5, 11'h241, rq, st, fa);
      chk("slow_req_cycles", 32'(rq), 32'd5);
      chk("slow_stall_cycles", 32'(st), 32'd5);
      chk("slow_fetch_addr", 32'(fa), 32'd1);
      chk("slow_opcode", 32'(opcode), 32'd4);
      chk("slow_addr", 32'(addr), 32'd65);

      // No ACK: abort after 15 REQ cycles.
      to_idle();
      run_fetch(0, 11'h000, rq, st, fa);
      chk("to_req_cycles", 32'(rq), 32'd15);
      chk("to_stall_cycles", 32'(st), 32'd15);
      chk("to_opcode", 32'(opcode), 32'hF);
      chk("to_addr", 32'(addr), 32'd0);
      chk("to_err", 32'(fetch_err), 32'd1);

      // Good fetch afterwards; error flag stays set.
      to_idle();
      run_fetch(1, 11'h07E, rq, st, fa);
      chk("good_req_cycles", 32'(rq), 32'd1);
      chk("good_stall_cycles", 32'(st), 32'd1);
      chk("good_addr", 32'(addr), 32'd126);
      chk("err_sticky", 32'(fetch_err), 32'd1);

      // Branch to 126, then wrap through 127, 0, 1.
      to_idle();
      pc_pulse(1'b1, 7'd126, "pc_load_126");
      pc_pulse(1'b0, 7'd127, "pc_inc_127");
      pc_pulse(1'b0, 7'd0, "pc_wrap_0");
      pc_pulse(1'b0, 7'd1, "pc_inc_1");

      run_fetch(1, 11'h040, rq, st, fa);
      chk("f40_fetch_addr", 32'(fa), 32'd1);
      to_idle();
      pc_pulse(1'b1, 7'd64, "pc_load_64");

      // Level held high for 5 cycles increments once.
      step();
      pc_en = 1'b1;
      repeat (4) step();
      step();
      pc_en = 1'b0;
      #1;
      chk("pc_level_once", 32'(pc), 32'd65);

      // Simultaneous rises, then a PC rise during REQ.
      step();
      ir_en = 1'b1;
      pc_en = 1'b1;
      #1;
      chk("sim_stall", 32'(stall), 32'd1);
      step();
      pc_en = 1'b0;
      #1;
      chk("sim_req", 32'(bus.IMEM_REQ), 32'd1);
      chk("sim_iaddr_old_pc", 32'(bus.IMEM_ADDR), 32'd65);
      chk("sim_pc_updated", 32'(pc), 32'd66);
      step();
      pc_en = 1'b1;
      #1;
      step();
      pc_en         = 1'b0;
      bus.IMEM_ACK  = 1'b1;
      bus.IMEM_DATA = 11'h0C5;
      #1;
      chk("req_pc_updated", 32'(pc), 32'd67);
      chk("req_iaddr_kept", 32'(bus.IMEM_ADDR), 32'd65);
      chk("req_stall_on_ack", 32'(stall), 32'd0);
      step();
      bus.IMEM_ACK = 1'b0;
      #1;
      chk("sim_opcode", 32'(opcode), 32'd1);

      // IR_EN held high in HOLD: no second fetch.
      rq = 0;
      st = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         #1;
         if (bus.IMEM_REQ) rq++;
         if (stall) st++;
      end
      chk("hold_no_req", 32'(rq), 32'd0);
      chk("hold_no_stall", 32'(st), 32'd0);

      // Reset in the middle of a fetch, then a late ACK.
      to_idle();
      step();
      ir_en = 1'b1;
      step();
      rst   = 1'b1;
      ir_en = 1'b0;
      #1;
      chk("rst_pre_req", 32'(bus.IMEM_REQ), 32'd1);
      step();
      rst           = 1'b0;
      bus.IMEM_ACK  = 1'b1;
      bus.IMEM_DATA = 11'h0C5;
      #1;
      chk("rst_req", 32'(bus.IMEM_REQ), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_pc", 32'(pc), 32'd0);
      chk("rst_iaddr", 32'(bus.IMEM_ADDR), 32'd0);
      chk("rst_err", 32'(fetch_err), 32'd0);
      step();
      bus.IMEM_ACK = 1'b0;
      #1;
      chk("rst_late_ack_op", 32'(opcode), 32'd0);
      chk("rst_late_ack_addr", 32'(addr), 32'd0);
      step();
      ir_en = 1'b1;
      #1;
      chk("rst_idle_stall", 32'(stall), 32'd1);
      step();
      ir_en = 1'b0;
      #1;
      chk("rst_idle_req", 32'(bus.IMEM_REQ), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
